// File: rtl/bias_ram_ctrl.sv
// Bias store sequencer: gathers a streamed row of bank words and writes it as a gap-free burst,
// then replays stored rows to the compute pipeline over a registered valid/ready port.
module bias_ram_ctrl #(
  parameter int unsigned pWEIGHT_DATA_WIDTH = 64,
  parameter logic [31:0] pWEIGHT_BASE_ADDR  = 32'h4000_0000,
  parameter int unsigned pBIAS_NUM          = 32,
  parameter int unsigned pBLOCK_RAM_NUM     = 32
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          load_start,
  input  logic                                          s_valid,
  input  logic [pWEIGHT_DATA_WIDTH-1:0]                 s_data,
  output logic                                          s_ready,
  output logic                                          wr_en,
  output logic [31:0]                                   weight_addr,
  output logic [pWEIGHT_DATA_WIDTH-1:0]                 weight_data,
  output logic                                          load_done,
  input  logic                                          rd_start,
  input  logic [$clog2(pBIAS_NUM+1)-1:0]                rd_count,
  output logic [$clog2(pBIAS_NUM)-1:0]                  bias_addr,
  input  logic [pWEIGHT_DATA_WIDTH*pBLOCK_RAM_NUM-1:0]  bias_data_in,
  output logic                                          m_valid,
  output logic [pWEIGHT_DATA_WIDTH*pBLOCK_RAM_NUM-1:0]  m_data,
  input  logic                                          m_ready,
  output logic                                          rd_done,
  output logic                                          busy,
  output logic                                          err
);
  localparam int DW = pWEIGHT_DATA_WIDTH;
  localparam int N  = pBLOCK_RAM_NUM;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam int RW = $clog2(pBIAS_NUM + 1);
  localparam int AW = $clog2(pBIAS_NUM);

  typedef enum logic [2:0] {IDLE, FILL, BURST, RD_ADDR, RD_WAIT, RD_OUT} state_e;

  state_e            state_q, state_d;
  logic [KW-1:0]     k_q, k_d, j_q, j_d;
  logic [RW-1:0]     row_q, row_d, r_q, r_d, cnt_q, cnt_d;
  logic [DW-1:0]     wbuf_q [N];
  logic [DW-1:0]     wbuf_d [N];
  logic              wr_en_q, wr_en_d, load_done_q, load_done_d;
  logic [31:0]       weight_addr_q, weight_addr_d;
  logic [DW-1:0]     weight_data_q, weight_data_d;
  logic [AW-1:0]     bias_addr_q, bias_addr_d;
  logic              m_valid_q, m_valid_d, rd_done_q, rd_done_d;
  logic [N*DW-1:0]   m_data_q, m_data_d;
  logic              busy_q, busy_d, err_q, err_d;

  always_comb begin
    state_d       = state_q;
    k_d           = k_q;
    j_d           = j_q;
    row_d         = row_q;
    r_d           = r_q;
    cnt_d         = cnt_q;
    wbuf_d        = wbuf_q;
    wr_en_d       = 1'b0;
    weight_addr_d = weight_addr_q;
    weight_data_d = weight_data_q;
    load_done_d   = 1'b0;
    bias_addr_d   = bias_addr_q;
    m_valid_d     = m_valid_q;
    m_data_d      = m_data_q;
    rd_done_d     = 1'b0;
    err_d         = (state_q != IDLE) && (load_start || rd_start);
    unique case (state_q)
      IDLE: begin
        if (load_start) begin
          state_d = FILL;
          row_d   = '0;
          k_d     = '0;
          err_d   = rd_start;
        end else if (rd_start) begin
          state_d     = RD_ADDR;
          r_d         = '0;
          cnt_d       = (rd_count > RW'(pBIAS_NUM)) ? RW'(pBIAS_NUM) : rd_count;
          bias_addr_d = '0;
        end
      end
      FILL: begin
        if (s_valid) begin
          wbuf_d[k_q] = s_data;
          k_d         = k_q + 1'b1;
          // First burst word is launched on the same edge that captures the last one.
          if (k_q == KW'(N - 1)) begin
            state_d       = BURST;
            k_d           = '0;
            j_d           = '0;
            wr_en_d       = 1'b1;
            weight_addr_d = pWEIGHT_BASE_ADDR + 32'(row_q);
            weight_data_d = (N == 1) ? s_data : wbuf_q[0];
          end
        end
      end
      BURST: begin
        if (j_q == KW'(N - 1)) begin
          row_d = row_q + 1'b1;
          if (row_q == RW'(pBIAS_NUM - 1)) begin
            load_done_d = 1'b1;
            state_d     = IDLE;
          end else begin
            state_d = FILL;
            k_d     = '0;
          end
        end else begin
          j_d           = j_q + 1'b1;
          wr_en_d       = 1'b1;
          weight_data_d = wbuf_q[j_d];
        end
      end
      RD_ADDR: begin
        if (cnt_q == '0) begin
          rd_done_d = 1'b1;
          state_d   = IDLE;
        end else begin
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        m_data_d  = bias_data_in;
        m_valid_d = 1'b1;
        state_d   = RD_OUT;
      end
      RD_OUT: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          r_d       = r_q + 1'b1;
          if (r_d == cnt_q) begin
            rd_done_d = 1'b1;
            state_d   = IDLE;
          end else begin
            state_d     = RD_ADDR;
            bias_addr_d = AW'(r_d);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      k_q           <= '0;
      j_q           <= '0;
      row_q         <= '0;
      r_q           <= '0;
      cnt_q         <= '0;
      wbuf_q        <= '{default: '0};
      wr_en_q       <= 1'b0;
      weight_addr_q <= '0;
      weight_data_q <= '0;
      load_done_q   <= 1'b0;
      bias_addr_q   <= '0;
      m_valid_q     <= 1'b0;
      m_data_q      <= '0;
      rd_done_q     <= 1'b0;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      k_q           <= k_d;
      j_q           <= j_d;
      row_q         <= row_d;
      r_q           <= r_d;
      cnt_q         <= cnt_d;
      wbuf_q        <= wbuf_d;
      wr_en_q       <= wr_en_d;
      weight_addr_q <= weight_addr_d;
      weight_data_q <= weight_data_d;
      load_done_q   <= load_done_d;
      bias_addr_q   <= bias_addr_d;
      m_valid_q     <= m_valid_d;
      m_data_q      <= m_data_d;
      rd_done_q     <= rd_done_d;
      busy_q        <= busy_d;
      err_q         <= err_d;
    end
  end

  assign s_ready     = (state_q == FILL);
  assign wr_en       = wr_en_q;
  assign weight_addr = weight_addr_q;
  assign weight_data = weight_data_q;
  assign load_done   = load_done_q;
  assign bias_addr   = bias_addr_q;
  assign m_valid     = m_valid_q;
  assign m_data      = m_data_q;
  assign rd_done     = rd_done_q;
  assign busy        = busy_q;
  assign err         = err_q;
endmodule

// File: tb/tb_bias_ram_ctrl.sv
// Bench for bias_ram_ctrl with a banked store model (self-clearing bank pointer, registered read).
module tb_bias_ram_ctrl;
  localparam int DW = 64;
  localparam int N  = 4;
  localparam int BN = 4;
  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam int CW = $clog2(BN + 1);
  localparam int AW = $clog2(BN);
  localparam int PW = $clog2(N);

  logic            clk = 1'b0, rst_n = 1'b0;
  logic            load_start = 1'b0, s_valid = 1'b0, rd_start = 1'b0, m_ready = 1'b0;
  logic [DW-1:0]   s_data = '0;
  logic [CW-1:0]   rd_count = '0;
  logic            s_ready, wr_en, load_done, m_valid, rd_done, busy, err;
  logic [31:0]     weight_addr;
  logic [DW-1:0]   weight_data;
  logic [AW-1:0]   bias_addr;
  logic [N*DW-1:0] bias_data_in, m_data, row2_dat;

  int n_vec = 0, n_err = 0, cyc = 0;
  logic [DW-1:0] words   [N*BN];
  logic [DW-1:0] exp_mem [N][BN];
  logic [DW-1:0] st_mem  [N][BN];
  logic [PW-1:0] st_ptr;
  logic [31:0]   wofs;

  bias_ram_ctrl #(
    .pWEIGHT_DATA_WIDTH(DW), .pWEIGHT_BASE_ADDR(BASE), .pBIAS_NUM(BN), .pBLOCK_RAM_NUM(N)
  ) dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .wr_en(wr_en), .weight_addr(weight_addr), .weight_data(weight_data),
    .load_done(load_done), .rd_start(rd_start), .rd_count(rd_count), .bias_addr(bias_addr),
    .bias_data_in(bias_data_in), .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .rd_done(rd_done), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Store: each write lands in the bank under the pointer; an idle pointer at the last bank clears.
  assign wofs = weight_addr - BASE;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_ptr       <= '0;
      bias_data_in <= '0;
      for (int b = 0; b < N; b++)
        for (int r = 0; r < BN; r++) st_mem[b][r] <= '0;
    end else begin
      for (int b = 0; b < N; b++) bias_data_in[b*DW +: DW] <= st_mem[b][bias_addr];
      if (wr_en) begin
        if (wofs < BN) st_mem[st_ptr][wofs[AW-1:0]] <= weight_data;
        st_ptr <= (st_ptr == PW'(N - 1)) ? '0 : st_ptr + 1'b1;
      end else if (st_ptr == PW'(N - 1)) begin
        st_ptr <= '0;
      end
    end
  end

  task automatic check(input string tag, input logic [N*DW-1:0] got, input logic [N*DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [N*DW-1:0] exp_row(input int row);
    logic [N*DW-1:0] v = '0;
    if (row < BN)
      for (int b = 0; b < N; b++) v[b*DW +: DW] = exp_mem[b][row];
    return v;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_s_ready"}, s_ready, 0);
    check({tag, "_wr_en"}, wr_en, 0);
    check({tag, "_waddr"}, weight_addr, 0);
    check({tag, "_wdata"}, weight_data, 0);
    check({tag, "_load_done"}, load_done, 0);
    check({tag, "_bias_addr"}, bias_addr, 0);
    check({tag, "_m_valid"}, m_valid, 0);
    check({tag, "_m_data"}, m_data, 0);
    check({tag, "_rd_done"}, rd_done, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_err"}, err, 0);
  endtask

  // Streams words[] in; checks write order/addresses, burst contiguity, load_done and err pulses.
  task automatic do_load(input bit gaps, input bit both, input int inject_at, input int abort_at);
    int idx = 0, nw = 0, nld = 0, nerr = 0, ld_cyc = -1, t = 0;
    int wcyc [$];
    logic [31:0] waddr [$];
    logic [DW-1:0] wdat [$];
    for (int r = 0; r < BN; r++)
      for (int b = 0; b < N; b++) exp_mem[b][r] = words[r*N + b];
    load_start = 1'b1;
    rd_start   = both;
    @(negedge clk);
    load_start = 1'b0;
    rd_start   = 1'b0;
    while (t < 400 && nld == 0) begin
      if (err) nerr++;
      if (load_done) begin nld++; ld_cyc = cyc; end
      rd_start = 1'b0;
      if (wr_en) begin
        wcyc.push_back(cyc);
        waddr.push_back(weight_addr);
        wdat.push_back(weight_data);
        if (nw == inject_at) rd_start = 1'b1;
        nw++;
        if (nw == abort_at + 1) begin
          rst_n = 1'b0;
          #1;
          check_all_zero("abort");
          check("abort_no_done", nld, 0);
          for (int r = 0; r < BN; r++)
            for (int b = 0; b < N; b++) exp_mem[b][r] = '0;
          s_valid = 1'b0;
          @(negedge clk);
          rst_n = 1'b1;
          @(negedge clk);
          return;
        end
      end
      s_valid = (idx < N*BN) && (!gaps || $urandom_range(0, 1) == 1);
      s_data  = s_valid ? words[idx] : {$urandom, $urandom};
      if (s_valid && s_ready) idx++;
      @(negedge clk);
      t++;
    end
    s_valid = 1'b0;
    check("load_done_cnt", nld, 1);
    check("write_cnt", nw, N*BN);
    for (int w = 0; w < nw && w < N*BN; w++) begin
      check("waddr", waddr[w], BASE + w / N);
      check("wdata", wdat[w], words[w]);
      if (w % N != 0) check("burst_gap", wcyc[w] - wcyc[w-1], 1);
    end
    if (nw > 0) check("done_lat", ld_cyc - wcyc[nw-1], 1);
    check("err_pulses", nerr, int'(both) + int'(inject_at >= 0));
    for (int r = 0; r < BN; r++)
      for (int b = 0; b < N; b++) check("store", st_mem[b][r], exp_mem[b][r]);
  endtask

  // Reads cnt rows; row hold_row is refused for hold_n cycles with m_valid high.
  task automatic do_read(input int cnt, input int hold_row, input int hold_n, input bit rnd);
    int got = 0, t = 0, held = 0, hs_cyc = -1, dn_cyc = -1, st_cyc, nvalid = 0;
    int exp_rows = (cnt > BN) ? BN : cnt;
    rd_start = 1'b1;
    rd_count = CW'(cnt);
    st_cyc   = cyc;
    @(negedge clk);
    rd_start = 1'b0;
    while (t < 300 && dn_cyc < 0) begin
      if (rd_done) dn_cyc = cyc;
      m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (m_valid) begin
        nvalid++;
        check("row_data", m_data, exp_row(got));
        if (got == hold_row && held < hold_n) begin m_ready = 1'b0; held++; end
        if (m_ready) begin
          if (got == 2) row2_dat = m_data;
          got++;
          hs_cyc = cyc;
        end
      end
      @(negedge clk);
      t++;
    end
    m_ready = 1'b0;
    check("rd_done_seen", dn_cyc >= 0, 1);
    check("rows_read", got, exp_rows);
    if (exp_rows == 0) begin
      check("zero_valid", nvalid, 0);
      check("zero_done_lat", dn_cyc - st_cyc, 2);
    end else begin
      check("done_lat", dn_cyc - hs_cyc, 1);
    end
    if (hold_row >= 0 && hold_row < exp_rows) check("held_cycles", held, hold_n);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < N*BN; i++) words[i] = DW'(8'h10 + i);
    do_load(1'b0, 1'b0, -1, -1);
    row2_dat = '0;
    do_read(4, -1, 0, 1'b0);
    check("row2_const", row2_dat, {64'h1B, 64'h1A, 64'h19, 64'h18});

    do_load(1'b1, 1'b0, -1, -1);
    do_read(3, 1, 5, 1'b0);
    do_read(0, -1, 0, 1'b0);

    do_load(1'b0, 1'b1, N + 1, -1);

    do_load(1'b0, 1'b0, -1, N + 2);
    do_load(1'b0, 1'b0, -1, -1);
    do_read(4, -1, 0, 1'b1);

    repeat (4) begin
      for (int i = 0; i < N*BN; i++) words[i] = {$urandom, $urandom};
      do_load(1'b1, 1'($urandom_range(0, 1)), $urandom_range(0, 1) == 1 ? int'($urandom_range(0, N*BN-1)) : -1, -1);
      do_read($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 6), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
